// File: rtl/mshr_l2_sched.sv
// mshr_l2_sched: schedules per-bank MSHR misses onto a single L2 request channel.
// One line-aligned request is in flight on the channel at a time. Each request is
// tagged {bank, MSHR ptr}. An outstanding-miss credit counter caps issue at MAX_OUT.
// L2 completions are routed back to the owning bank as a fin pulse plus the MSHR ptr.
//
// Build option: define MSHR_SCHED_RR_EN for round-robin arbitration. The search then
// starts at a pointer that moves past the last granted bank. When the macro is left
// undefined, arbitration is fixed priority and the lowest bank index wins.
//
// Handshake: l2_req_valid rises from IDLE one cycle after the grant. It stays high,
// with addr/op/tag held stable from the request register, until l2_req_ready is seen.
// That same cycle pulses bank_req_ack for the owning bank.
module mshr_l2_sched #(
   parameter int N_BANK   = 2,
   parameter int Q_LENGTH = 8,
   parameter int MAX_OUT  = 8,
   parameter int PW       = $clog2(Q_LENGTH),
   parameter int CW       = $clog2(MAX_OUT + 1),
   parameter int BW       = $clog2(N_BANK),
   parameter int TW       = BW + PW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_BANK-1:0]      bank_req_valid,
   input  logic [32*N_BANK-1:0]   bank_req_addr,
   input  logic [3*N_BANK-1:0]    bank_req_op,
   input  logic [PW*N_BANK-1:0]   bank_req_ptr,
   output logic [N_BANK-1:0]      bank_req_ack,
   output logic                   l2_req_valid,
   input  logic                   l2_req_ready,
   output logic [31:0]            l2_req_addr,
   output logic [2:0]             l2_req_op,
   output logic [TW-1:0]          l2_req_tag,
   input  logic                   l2_rsp_valid,
   input  logic [TW-1:0]          l2_rsp_tag,
   output logic [N_BANK-1:0]      fin_valid,
   output logic [PW-1:0]          fin_ptr,
   output logic [CW-1:0]          outstanding,
   output logic                   sched_err,
   output logic                   dbg_state
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   localparam logic [CW-1:0] MAX_W  = CW'(MAX_OUT);
   localparam logic [BW:0]   NB_W   = (BW + 1)'(N_BANK);
   localparam logic [BW-1:0] LAST_B = BW'(N_BANK - 1);

   state_t          r_state;
   logic            r_req_valid;
   logic [31:0]     r_addr;
   logic [2:0]      r_op;
   logic [PW-1:0]   r_ptr;
   logic [BW-1:0]   r_bank;
   logic [CW-1:0]   r_out;
   logic            r_err;
`ifdef MSHR_SCHED_RR_EN
   logic [BW-1:0]   r_rr;
`endif

   logic            w_found;
   logic [BW-1:0]   w_win;
   int              w_idx;
   logic [31:0]     w_sel_addr;
   logic [2:0]      w_sel_op;
   logic [PW-1:0]   w_sel_ptr;
   logic            w_credit;
   logic            w_issue;
   logic [BW-1:0]   w_rsp_bank;
   logic [PW-1:0]   w_rsp_ptr;
   logic            w_bank_ok;

   // Credits are judged on the registered count, so a completion in the same cycle
   // only opens a slot for the following cycle.
   assign w_credit = (r_out < MAX_W);
   assign w_issue  = r_req_valid & l2_req_ready;

   assign l2_req_valid = r_req_valid;
   assign l2_req_addr  = r_addr;
   assign l2_req_op    = r_op;
   assign l2_req_tag   = {r_bank, r_ptr};
   assign outstanding  = r_out;
   assign sched_err    = r_err;
   assign dbg_state    = r_state;

   // Pick the winning bank: a priority search from the RR pointer, or from bank 0.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int i = 0; i < N_BANK; i++) begin
`ifdef MSHR_SCHED_RR_EN
         w_idx = int'(r_rr) + i;
         if (w_idx >= N_BANK) w_idx = w_idx - N_BANK;
`else
         w_idx = i;
`endif
         if (!w_found && bank_req_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = BW'(w_idx);
         end
      end
      w_sel_addr = bank_req_addr[32*int'(w_win) +: 32];
      w_sel_op   = bank_req_op[3*int'(w_win) +: 3];
      w_sel_ptr  = bank_req_ptr[PW*int'(w_win) +: PW];
   end

   // Ack the owning bank in the cycle the L2 handshake completes.
   always_comb begin
      bank_req_ack = '0;
      if (w_issue) bank_req_ack[r_bank] = 1'b1;
   end

   // Route a completion straight back to its bank. A bank field that is out of range
   // produces no fin.
   always_comb begin
      w_rsp_bank = l2_rsp_tag[TW-1:PW];
      w_rsp_ptr  = l2_rsp_tag[PW-1:0];
      w_bank_ok  = ({1'b0, w_rsp_bank} < NB_W);
      fin_valid  = '0;
      fin_ptr    = '0;
      if (l2_rsp_valid) begin
         fin_ptr = w_rsp_ptr;
         if (w_bank_ok) fin_valid[w_rsp_bank] = 1'b1;
      end
   end

   // IDLE/SEND request FSM. It owns the latched request and the RR pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_req_valid <= 1'b0;
         r_addr      <= '0;
         r_op        <= '0;
         r_ptr       <= '0;
         r_bank      <= '0;
`ifdef MSHR_SCHED_RR_EN
         r_rr        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found && w_credit) begin
                  r_addr      <= w_sel_addr & 32'hFFFF_FFF0;
                  r_op        <= w_sel_op;
                  r_ptr       <= w_sel_ptr;
                  r_bank      <= w_win;
                  r_req_valid <= 1'b1;
                  r_state     <= S_SEND;
               end
            end
            S_SEND: begin
               if (l2_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_IDLE;
`ifdef MSHR_SCHED_RR_EN
                  r_rr        <= (r_bank == LAST_B) ? '0 : r_bank + BW'(1);
`endif
               end
            end
            default: begin
               r_req_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   // Outstanding-miss credit counter and the sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_issue && !l2_rsp_valid) begin
            r_out <= r_out + CW'(1);
         end else if (!w_issue && l2_rsp_valid && (r_out != '0)) begin
            r_out <= r_out - CW'(1);
         end
         if (l2_rsp_valid && ((r_out == '0) || !w_bank_ok)) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mshr_l2_sched.sv
// Bench for mshr_l2_sched. Each scenario runs as its own task.
// A negedge monitor pops expected L2 requests from exp_q at every handshake.
module tb_mshr_l2_sched;

  localparam int N_BANK = 2;
  localparam int PW     = 3;
  localparam int CW     = 4;
  localparam int TW     = 4;
  localparam int EW     = 32 + 3 + TW;

  logic                  clk;
  logic                  rst;
  logic [N_BANK-1:0]     bank_req_valid;
  logic [32*N_BANK-1:0]  bank_req_addr;
  logic [3*N_BANK-1:0]   bank_req_op;
  logic [PW*N_BANK-1:0]  bank_req_ptr;
  logic [N_BANK-1:0]     bank_req_ack;
  logic                  l2_req_valid;
  logic                  l2_req_ready;
  logic [31:0]           l2_req_addr;
  logic [2:0]            l2_req_op;
  logic [TW-1:0]         l2_req_tag;
  logic                  l2_rsp_valid;
  logic [TW-1:0]         l2_rsp_tag;
  logic [N_BANK-1:0]     fin_valid;
  logic [PW-1:0]         fin_ptr;
  logic [CW-1:0]         outstanding;
  logic                  sched_err;
  logic                  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  mshr_l2_sched #(.N_BANK(N_BANK), .Q_LENGTH(8), .MAX_OUT(8)) dut (
    .clk(clk), .rst(rst),
    .bank_req_valid(bank_req_valid), .bank_req_addr(bank_req_addr),
    .bank_req_op(bank_req_op), .bank_req_ptr(bank_req_ptr),
    .bank_req_ack(bank_req_ack),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_addr(l2_req_addr), .l2_req_op(l2_req_op), .l2_req_tag(l2_req_tag),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_tag(l2_rsp_tag),
    .fin_valid(fin_valid), .fin_ptr(fin_ptr),
    .outstanding(outstanding), .sched_err(sched_err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard monitor: every L2 handshake must match the head of exp_q
  always @(negedge clk) begin
    if (rst && l2_req_valid && l2_req_ready) begin
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL l2_req_unexpected got addr=%h op=%0d tag=%h with empty queue", l2_req_addr, l2_req_op, l2_req_tag);
      end else begin
        e = exp_q.pop_front();
        if ({l2_req_addr, l2_req_op, l2_req_tag} !== e) begin
          errors++;
          $display("FAIL l2_req_fields got %h exp %h", {l2_req_addr, l2_req_op, l2_req_tag}, e);
        end
      end
      checks++;
      if (bank_req_ack !== (2'b01 << l2_req_tag[TW-1])) begin
        errors++;
        $display("FAIL ack_owner got %b exp %b", bank_req_ack, 2'b01 << l2_req_tag[TW-1]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input int b, input logic [31:0] a, input logic [2:0] op,
                          input logic [2:0] p, input logic v);
    bank_req_addr[32*b +: 32] = a;
    bank_req_op[3*b +: 3]     = op;
    bank_req_ptr[PW*b +: PW]  = p;
    bank_req_valid[b]         = v;
  endtask

  function automatic logic [EW-1:0] exp_word(input logic [31:0] a, input logic [2:0] op,
                                             input int b, input logic [2:0] p);
    logic [31:0] al;
    al = {a[31:4], 4'h0};
    return {al, op, b[0], p};
  endfunction

  task automatic clear_inputs();
    bank_req_valid = '0;
    bank_req_addr  = '0;
    bank_req_op    = '0;
    bank_req_ptr   = '0;
    l2_req_ready   = 1'b0;
    l2_rsp_valid   = 1'b0;
    l2_rsp_tag     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_rsp(input logic [TW-1:0] tag);
    l2_rsp_valid = 1'b1;
    l2_rsp_tag   = tag;
    tick();
    l2_rsp_valid = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({l2_req_valid, bank_req_ack, fin_valid, fin_ptr, l2_req_op, l2_req_tag,
         outstanding, sched_err, dbg_state} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b ack=%b fin=%b ptr=%0d op=%0d tag=%h out=%0d err=%b st=%b exp all 0",
               l2_req_valid, bank_req_ack, fin_valid, fin_ptr, l2_req_op, l2_req_tag, outstanding, sched_err, dbg_state);
    end
    checks++;
    if (l2_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got %h exp 0", l2_req_addr);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single_miss();
    do_reset();
    l2_req_ready = 1'b1;
    set_bank(0, 32'h1234_5678, 3'd5, 3'd3, 1'b1);
    exp_q.push_back(exp_word(32'h1234_5678, 3'd5, 0, 3'd3));
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early got valid=%b exp 0", l2_req_valid);
    end
    @(negedge clk);
    checks++;
    if ({l2_req_valid, bank_req_ack} !== 3'b101) begin
      errors++;
      $display("FAIL single_ack got valid=%b ack=%b exp valid=1 ack=01", l2_req_valid, bank_req_ack);
    end
    checks++;
    if (l2_req_addr !== 32'h1234_5670 || l2_req_tag !== 4'h3) begin
      errors++;
      $display("FAIL single_addr_tag got %h/%h exp 12345670/3", l2_req_addr, l2_req_tag);
    end
    tick();
    set_bank(0, 32'h0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd1) begin
      errors++;
      $display("FAIL single_out_inc got %0d exp 1", outstanding);
    end
    l2_rsp_valid = 1'b1;
    l2_rsp_tag   = 4'h3;
    #1;
    checks++;
    if (fin_valid !== 2'b01 || fin_ptr !== 3'd3) begin
      errors++;
      $display("FAIL single_fin got fin=%b ptr=%0d exp 01/3", fin_valid, fin_ptr);
    end
    tick();
    l2_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd0 || fin_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_out_dec got out=%0d fin=%b exp 0/00", outstanding, fin_valid);
    end
  endtask

  task automatic test_contention();
    int g[$];
    int exp_g[4];
    do_reset();
    l2_req_ready = 1'b1;
    set_bank(0, 32'h1000_0008, 3'd1, 3'd1, 1'b1);
    set_bank(1, 32'h2000_000c, 3'd6, 3'd2, 1'b1);
    for (int k = 0; k < 4; k++) begin
`ifdef MSHR_SCHED_RR_EN
      exp_g[k] = k % 2;
`else
      exp_g[k] = 0;
`endif
      if (exp_g[k] == 0) exp_q.push_back(exp_word(32'h1000_0008, 3'd1, 0, 3'd1));
      else               exp_q.push_back(exp_word(32'h2000_000c, 3'd6, 1, 3'd2));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bank_req_ack == 2'b01)      g.push_back(0);
      else if (bank_req_ack == 2'b10) g.push_back(1);
      else if (bank_req_ack != 2'b00) g.push_back(9);
    end
    tick();
    bank_req_valid = '0;
    checks++;
    if (g.size() != 4) begin
      errors++;
      $display("FAIL contention_count got %0d grants exp 4", g.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g[k] != exp_g[k]) begin
          errors++;
          $display("FAIL contention_order grant %0d got bank %0d exp bank %0d", k, g[k], exp_g[k]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd4) begin
      errors++;
      $display("FAIL contention_out got %0d exp 4", outstanding);
    end
    repeat (4) send_rsp(4'h1);
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd0) begin
      errors++;
      $display("FAIL contention_drain got %0d exp 0", outstanding);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] out0;
    logic [31:0] a;
    a = 32'hdead_0000 | 32'($urandom_range(0, 16'hffff));
    out0 = outstanding;
    l2_req_ready = 1'b0;
    set_bank(1, a, 3'd2, 3'd7, 1'b1);
    exp_q.push_back(exp_word(a, 3'd2, 1, 3'd7));
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (l2_req_valid !== 1'b1 || bank_req_ack !== 2'b00 ||
          l2_req_addr !== {a[31:4], 4'h0} || l2_req_op !== 3'd2 || l2_req_tag !== 4'hf) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d got v=%b ack=%b addr=%h op=%0d tag=%h exp 1/00/%h/2/f",
                 c, l2_req_valid, bank_req_ack, l2_req_addr, l2_req_op, l2_req_tag, {a[31:4], 4'h0});
      end
    end
    tick();
    l2_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bank_req_ack !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_ack got %b exp 10", bank_req_ack);
    end
    tick();
    bank_req_valid = '0;
    @(negedge clk);
    checks++;
    if (outstanding !== out0 + 4'd1 || bank_req_ack !== 2'b00) begin
      errors++;
      $display("FAIL backpressure_out got out=%0d ack=%b exp %0d/00", outstanding, bank_req_ack, out0 + 4'd1);
    end
    send_rsp(4'hf);
  endtask

  task automatic test_credit_limit();
    int acks;
    do_reset();
    l2_req_ready = 1'b1;
    set_bank(0, 32'h3000_0040, 3'd4, 3'd0, 1'b1);
    repeat (9) exp_q.push_back(exp_word(32'h3000_0040, 3'd4, 0, 3'd0));
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bank_req_ack != 2'b00) acks++;
    end
    checks++;
    if (acks != 8 || outstanding !== 4'd8) begin
      errors++;
      $display("FAIL credit_fill got acks=%0d out=%0d exp 8/8", acks, outstanding);
    end
    checks++;
    if (l2_req_valid !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL credit_block got valid=%b state=%b exp 0/0", l2_req_valid, dbg_state);
    end
    tick();
    l2_rsp_valid = 1'b1;
    l2_rsp_tag   = 4'h0;
    @(negedge clk);
    checks++;
    if (fin_valid !== 2'b01 || l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_rsp got fin=%b valid=%b exp 01/0", fin_valid, l2_req_valid);
    end
    tick();
    l2_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd7 || l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL credit_no_same_cycle_grant got out=%0d valid=%b exp 7/0", outstanding, l2_req_valid);
    end
    tick();
    l2_rsp_valid = 1'b1;
    l2_rsp_tag   = 4'h1;
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b1 || bank_req_ack !== 2'b01) begin
      errors++;
      $display("FAIL credit_regrant got valid=%b ack=%b exp 1/01", l2_req_valid, bank_req_ack);
    end
    tick();
    l2_rsp_valid   = 1'b0;
    bank_req_valid = '0;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd7) begin
      errors++;
      $display("FAIL credit_issue_and_rsp got %0d exp 7", outstanding);
    end
    repeat (7) send_rsp(4'h0);
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd0 || sched_err !== 1'b0) begin
      errors++;
      $display("FAIL credit_drain got out=%0d err=%b exp 0/0", outstanding, sched_err);
    end
  endtask

  task automatic test_spurious();
    l2_rsp_valid = 1'b1;
    l2_rsp_tag   = 4'hd;
    #1;
    checks++;
    if (fin_valid !== 2'b10 || fin_ptr !== 3'd5) begin
      errors++;
      $display("FAIL spurious_fin got fin=%b ptr=%0d exp 10/5", fin_valid, fin_ptr);
    end
    tick();
    l2_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sched_err !== 1'b1 || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL spurious_err got err=%b out=%0d exp 1/0", sched_err, outstanding);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sched_err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky got %b exp 1", sched_err);
    end
  endtask

  task automatic test_reset_mid_send();
    l2_req_ready = 1'b0;
    set_bank(0, 32'h4444_4444, 3'd3, 3'd4, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL midsend_setup got valid=%b exp 1", l2_req_valid);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({l2_req_valid, bank_req_ack, l2_req_op, l2_req_tag, outstanding, sched_err, dbg_state} !== 16'd0 ||
        l2_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL midsend_async got v=%b ack=%b addr=%h op=%0d tag=%h out=%0d err=%b st=%b exp all 0",
               l2_req_valid, bank_req_ack, l2_req_addr, l2_req_op, l2_req_tag, outstanding, sched_err, dbg_state);
    end
    l2_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bank_req_ack !== 2'b00 || l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midsend_held got ack=%b valid=%b exp 00/0", bank_req_ack, l2_req_valid);
    end
    exp_q.push_back(exp_word(32'h4444_4444, 3'd3, 0, 3'd4));
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (l2_req_valid !== 1'b0 || bank_req_ack !== 2'b00) begin
      errors++;
      $display("FAIL midsend_release got valid=%b ack=%b exp 0/00", l2_req_valid, bank_req_ack);
    end
    @(negedge clk);
    checks++;
    if (bank_req_ack !== 2'b01) begin
      errors++;
      $display("FAIL midsend_reissue got ack=%b exp 01", bank_req_ack);
    end
    tick();
    bank_req_valid = '0;
    @(negedge clk);
    checks++;
    if (outstanding !== 4'd1) begin
      errors++;
      $display("FAIL midsend_out got %0d exp 1", outstanding);
    end
    send_rsp(4'h4);
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_single_miss();
    test_contention();
    test_backpressure();
    test_credit_limit();
    test_spurious();
    test_reset_mid_send();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
